// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Purpose: instruction fetch stage for a multi-cycle processor. It holds the
// program counter and instruction register. On request it reads one
// instruction word from memory, and a fetch that is never acknowledged is
// abandoned after a bounded number of cycles.
//
// Ports:
//   clk_i            single clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   start_i          request a fetch at the current PC (honoured in IDLE only)
//   pc_write_i       unconditional PC load (IDLE only)
//   pc_write_cond_i  PC load qualified by zero_i (IDLE only)
//   zero_i           ALU zero flag
//   pc_source_i      next-PC select: 0 alu_result, 1 alu_out, 2 jump_target,
//                    3 rs_data
//   alu_result_i, alu_out_i, rs_data_i   candidate next-PC values
//   mem_ack_i        memory read-data valid strobe
//   mem_data_i       instruction word from memory
//   mem_req_o        memory read request (FETCH only)
//   mem_addr_o       memory read address (PC during FETCH, else 0)
//   pc_o             program counter
//   ir_o             instruction register
//   jump_target_o    {pc[31:28], ir[25:0], 2'b00}
//   ir_valid_o       one-cycle pulse after ir_o has been loaded
//   busy_o           high in any state other than IDLE
//   mem_err_o        one-cycle pulse after a fetch timed out
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        pc_write_i,
    input  logic        pc_write_cond_i,
    input  logic        zero_i,
    input  logic [1:0]  pc_source_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] rs_data_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] jump_target_o,
    output logic        ir_valid_o,
    output logic        busy_o,
    output logic        mem_err_o
);

    // The wait counter only has to reach ACK_TIMEOUT-1, so it is sized for
    // that and never needs to hold ACK_TIMEOUT itself.
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetchState_e;

    fetchState_e   state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [CW-1:0] waitCount_q, waitCount_d;
    logic          memErr_q, memErr_d;

    logic [31:0]   jumpTarget;
    logic [31:0]   pcSel;
    logic          pcLoad;

    // The jump target comes from the registered PC, which has already been
    // advanced past the jump instruction, so the upper nibble is that of PC+4.
    assign jumpTarget = {pc_q[31:28], ir_q[25:0], 2'b00};

    // Candidate next PC selected by the controller. The low two bits are
    // cleared so the PC always stays word aligned.
    always_comb begin
        pcSel = 32'h0000_0000;
        case (pc_source_i)
            2'd0:    pcSel = alu_result_i;
            2'd1:    pcSel = alu_out_i;
            2'd2:    pcSel = jumpTarget;
            default: pcSel = rs_data_i;
        endcase
        pcSel[1:0] = 2'b00;
    end

    assign pcLoad = pc_write_i | (pc_write_cond_i & zero_i);

    // Next-state and datapath update logic. PC loads are honoured only in
    // IDLE, where they can coincide with start so the fetch that follows
    // uses the freshly loaded PC. In FETCH an acknowledge captures the
    // instruction and advances the PC. Running out of wait cycles abandons
    // the fetch with PC and IR untouched and raises the error pulse.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        waitCount_d = waitCount_q;
        memErr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                waitCount_d = '0;
                if (pcLoad) begin
                    pc_d = pcSel;
                end
                if (start_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack_i) begin
                    ir_d        = mem_data_i;
                    pc_d        = pc_q + 32'd4;
                    waitCount_d = '0;
                    state_d     = DONE;
                end else if (waitCount_q == LAST_WAIT) begin
                    memErr_d    = 1'b1;
                    waitCount_d = '0;
                    state_d     = IDLE;
                end else begin
                    waitCount_d = waitCount_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                waitCount_d = '0;
            end
        endcase
    end

    // State register. Reset is synchronous and overrides every other
    // activity in the same cycle, including an acknowledge mid-fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 32'h0000_0000;
            waitCount_q <= '0;
            memErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            waitCount_q <= waitCount_d;
            memErr_q    <= memErr_d;
        end
    end

    // Outputs are decoded from the registered state so they are glitch free
    // and line up with the cycle in which each state is occupied.
    assign mem_req_o     = (state_q == FETCH);
    assign mem_addr_o    = (state_q == FETCH) ? pc_q : 32'h0000_0000;
    assign pc_o          = pc_q;
    assign ir_o          = ir_q;
    assign jump_target_o = jumpTarget;
    assign ir_valid_o    = (state_q == DONE);
    assign busy_o        = (state_q != IDLE);
    assign mem_err_o     = memErr_q;

endmodule
